sysid_regs: RTL and testbench

SYSID_REGS -- requirements
Module: sysid_regs

---
 rtl/sysid_pkg.sv | 21 ++
 rtl/sysid_uptime_cnt.sv | 53 +++++
 rtl/sysid_regs.sv | 101 ++++++++++
 tb/tb_sysid_regs.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/sysid_pkg.sv
// Shared constants for the system-ID register block: word map, CONTROL bits, CAPS layout.
package sysid_pkg;

  localparam logic [3:0] ADDR_ID        = 4'd0;
  localparam logic [3:0] ADDR_TIMESTAMP = 4'd1;
  localparam logic [3:0] ADDR_UPTIME_LO = 4'd2;
  localparam logic [3:0] ADDR_UPTIME_HI = 4'd3;
  localparam logic [3:0] ADDR_CAPS      = 4'd4;
  localparam logic [3:0] ADDR_CONTROL   = 4'd5;
  localparam logic [3:0] ADDR_SCRATCH0  = 4'd8;

  localparam int CTRL_CLEAR_BIT  = 0;
  localparam int CTRL_FREEZE_BIT = 1;

  localparam logic [15:0] CAPS_VERSION = 16'h0002;

  function automatic logic [31:0] caps_word(input int cnt_w, input int num_scratch);
    return {CAPS_VERSION, 8'(cnt_w), 8'(num_scratch)};
  endfunction

endpackage

// File: rtl/sysid_uptime_cnt.sv
// Free-running uptime counter with clear/freeze, plus the high-word shadow that a
// low-word read snapshots so a LO-then-HI read pair is coherent.
module sysid_uptime_cnt #(
  parameter int CNT_W = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             freeze_i,
  input  logic             snap_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [31:0]      shadow_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [63:0]      cnt_ext_s;

  assign cnt_ext_s = 64'(cnt_q);

  // Next-state: clear wins over freeze, so clear+freeze lands on 0 and holds there.
  always_comb begin
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (!freeze_i) begin
      cnt_d = cnt_q + CNT_W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
    if (snap_i) begin
      shadow_d = cnt_ext_s[63:32];
    end else begin
      shadow_d = shadow_q;
    end
  end

  // Counter and shadow state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      shadow_q <= 32'h0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign shadow_o = shadow_q;

endmodule

// File: rtl/sysid_regs.sv
// Avalon-MM system-ID / uptime / scratch register block with fixed one-cycle read latency.
module sysid_regs
  import sysid_pkg::*;
#(
  parameter logic [31:0] ID_VALUE    = 32'h557A_6E7B,
  parameter logic [31:0] TIMESTAMP   = 32'h0000_0000,
  parameter int          NUM_SCRATCH = 2,
  parameter int          CNT_W       = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  logic [CNT_W-1:0] cnt_s;
  logic [31:0]      shadow_s;
  logic             ctrl_wr_s, clear_s, snap_s;
  logic             freeze_q, freeze_d;
  logic [31:0]      scratch_q [NUM_SCRATCH];
  logic [31:0]      scratch_rd_s;
  logic [31:0]      rdata_d, readdata_q;
  logic             rvalid_q;

  assign ctrl_wr_s = write && (address == ADDR_CONTROL);
  assign clear_s   = ctrl_wr_s && writedata[CTRL_CLEAR_BIT];
  assign snap_s    = read && (address == ADDR_UPTIME_LO);

  sysid_uptime_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (clear_s),
    .freeze_i (freeze_q),
    .snap_i   (snap_s),
    .cnt_o    (cnt_s),
    .shadow_o (shadow_s)
  );

  // Freeze bit next-state; the clear bit is a pulse and is never stored.
  always_comb begin
    if (ctrl_wr_s) begin
      freeze_d = writedata[CTRL_FREEZE_BIT];
    end else begin
      freeze_d = freeze_q;
    end
  end

  // Scratch read mux: at most one word matches, unmatched words contribute 0.
  always_comb begin
    scratch_rd_s = 32'h0;
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      scratch_rd_s = scratch_rd_s |
                     ((address == (ADDR_SCRATCH0 + 4'(i))) ? scratch_q[i] : 32'h0);
    end
  end

  // Register read decode; everything unmapped falls through to the scratch mux.
  always_comb begin
    rdata_d = 32'h0;
    case (address)
      ADDR_ID:        rdata_d = ID_VALUE;
      ADDR_TIMESTAMP: rdata_d = TIMESTAMP;
      ADDR_UPTIME_LO: rdata_d = cnt_s[31:0];
      ADDR_UPTIME_HI: rdata_d = shadow_s;
      ADDR_CAPS:      rdata_d = caps_word(CNT_W, NUM_SCRATCH);
      ADDR_CONTROL:   rdata_d = {30'h0, freeze_q, 1'b0};
      default:        rdata_d = scratch_rd_s;
    endcase
  end

  // Read response, CONTROL and scratch storage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      readdata_q <= 32'h0;
      rvalid_q   <= 1'b0;
      freeze_q   <= 1'b0;
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        scratch_q[i] <= 32'h0;
      end
    end else begin
      rvalid_q <= read;
      if (read) begin
        readdata_q <= rdata_d;
      end
      freeze_q <= freeze_d;
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (write && (address == (ADDR_SCRATCH0 + 4'(i)))) begin
          scratch_q[i] <= writedata;
        end
      end
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = rvalid_q;

endmodule

// File: tb/tb_sysid_regs.sv
// Randomized bench for sysid_regs against a word-level behavioural model of the register map.
module tb_sysid_regs;

  localparam logic [31:0] ID   = 32'h557A_6E7B;
  localparam logic [31:0] TS   = 32'h6600_1234;
  localparam logic [31:0] CAPS = 32'h0002_4002;
  localparam int          NS   = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  address = 4'd0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic        readdatavalid;

  sysid_regs #(.ID_VALUE(ID), .TIMESTAMP(TS), .NUM_SCRATCH(NS), .CNT_W(64)) dut (
    .clock         (clock),
    .reset         (reset),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  longint unsigned m_cnt;
  logic [31:0]     m_shadow;
  logic            m_freeze;
  logic [31:0]     m_scr [16];
  logic [31:0]     m_last;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] a);
    case (a)
      4'd0:    return ID;
      4'd1:    return TS;
      4'd2:    return m_cnt[31:0];
      4'd3:    return m_shadow;
      4'd4:    return CAPS;
      4'd5:    return {30'h0, m_freeze, 1'b0};
      default: return (a >= 4'd8 && int'(a) < 8 + NS) ? m_scr[a] : 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    m_cnt = 64'd0; m_shadow = 32'h0; m_freeze = 1'b0; m_last = 32'h0;
    for (int i = 0; i < 16; i++) m_scr[i] = 32'h0;
  endtask

  task automatic m_step(input logic rd, input logic wr, input logic [3:0] a, input logic [31:0] wd);
    if (rd && a == 4'd2) m_shadow = m_cnt[63:32];
    if (wr && a == 4'd5 && wd[0]) m_cnt = 64'd0;
    else if (!m_freeze) m_cnt = m_cnt + 64'd1;
    if (wr && a == 4'd5) m_freeze = wd[1];
    if (wr && a >= 4'd8 && int'(a) < 8 + NS) m_scr[a] = wd;
  endtask

  // One bus cycle: drive, clock, update model, then check the response after the edge.
  task automatic cycle(input logic rd, input logic wr, input logic [3:0] a,
                       input logic [31:0] wd, output logic [31:0] got);
    logic [31:0] exp;
    read = rd; write = wr; address = a; writedata = wd;
    exp = m_read(a);
    @(posedge clock);
    m_step(rd, wr, a, wd);
    #1;
    if (rd) m_last = exp;
    chk($sformatf("rvalid a=%0d rd=%0d", a, rd), readdatavalid, rd);
    chk($sformatf("rdata a=%0d rd=%0d", a, rd), readdata, m_last);
    got = readdata;
    read = 1'b0; write = 1'b0;
  endtask

  logic [31:0] g, g2;

  initial begin
    m_reset();
    #1;
    chk("reset_rdata", readdata, 32'h0);
    chk("reset_rvalid", readdatavalid, 1'b0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;

    // Counter starts on the first edge after release
    cycle(1'b1, 1'b0, 4'd2, 32'h0, g);
    chk("uptime_first", g, 32'd0);
    cycle(1'b0, 1'b0, 4'd0, 32'h0, g);
    cycle(1'b1, 1'b0, 4'd2, 32'h0, g);
    chk("uptime_third", g, 32'd2);

    cycle(1'b1, 1'b0, 4'd0, 32'h0, g);  chk("id", g, ID);
    cycle(1'b1, 1'b0, 4'd4, 32'h0, g);  chk("caps", g, CAPS);
    cycle(1'b0, 1'b1, 4'd8, 32'hDEAD_BEEF, g);
    cycle(1'b1, 1'b0, 4'd8, 32'h0, g);  chk("scratch8", g, 32'hDEAD_BEEF);
    cycle(1'b0, 1'b1, 4'd1, 32'h1234_5678, g);
    cycle(1'b1, 1'b0, 4'd1, 32'h0, g);  chk("ts_ro", g, TS);
    cycle(1'b0, 1'b1, 4'd6, 32'hFFFF_FFFF, g);
    cycle(1'b1, 1'b0, 4'd6, 32'h0, g);  chk("unmapped6", g, 32'h0);
    cycle(1'b0, 1'b1, 4'd10, 32'h1111_2222, g);
    cycle(1'b1, 1'b0, 4'd10, 32'h0, g); chk("unmapped10", g, 32'h0);

    // Same-cycle read+write returns old value
    cycle(1'b0, 1'b1, 4'd9, 32'd5, g);
    cycle(1'b1, 1'b1, 4'd9, 32'd7, g);  chk("rw_old", g, 32'd5);
    cycle(1'b1, 1'b0, 4'd9, 32'h0, g);  chk("rw_new", g, 32'd7);

    // Freeze holds the counter
    cycle(1'b0, 1'b1, 4'd5, 32'd2, g);
    cycle(1'b1, 1'b0, 4'd2, 32'h0, g);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 4'd0, 32'h0, g2);
    cycle(1'b1, 1'b0, 4'd2, 32'h0, g2); chk("freeze_hold", g2, g);

    // Clear+freeze: counter goes to 0 and stays
    cycle(1'b0, 1'b1, 4'd5, 32'd3, g);
    cycle(1'b0, 1'b0, 4'd0, 32'h0, g);
    cycle(1'b1, 1'b0, 4'd2, 32'h0, g);  chk("clear_lo", g, 32'd0);
    cycle(1'b1, 1'b0, 4'd5, 32'h0, g);  chk("control", g, 32'd2);

    // Backdoor the frozen counter just below the 32-bit wrap
    dut.u_cnt.cnt_q = 64'h0000_0000_FFFF_FFFE;
    m_cnt = 64'h0000_0000_FFFF_FFFE;
    cycle(1'b0, 1'b1, 4'd5, 32'd0, g);
    cycle(1'b0, 1'b0, 4'd0, 32'h0, g);
    cycle(1'b1, 1'b0, 4'd2, 32'h0, g);  chk("wrap_lo", g, 32'hFFFF_FFFF);
    cycle(1'b0, 1'b0, 4'd0, 32'h0, g);
    cycle(1'b1, 1'b0, 4'd3, 32'h0, g);  chk("wrap_hi_shadow", g, 32'h0);
    cycle(1'b1, 1'b0, 4'd2, 32'h0, g);
    cycle(1'b1, 1'b0, 4'd3, 32'h0, g);  chk("hi_after_wrap", g, 32'h1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [3:0]  a;
      logic [31:0] wd;
      a  = 4'($urandom_range(0, 15));
      wd = $urandom;
      if (a == 4'd5) wd[0] = ($urandom_range(0, 7) == 0);
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, wd, g);
    end

    // Reset asserted during a read: no pulse, scratch cleared
    cycle(1'b0, 1'b1, 4'd8, 32'hA5A5_A5A5, g);
    cycle(1'b0, 1'b1, 4'd9, 32'h5A5A_5A5A, g);
    read = 1'b1; address = 4'd8; reset = 1'b1;
    m_reset();
    #1;
    chk("rst_imm_rvalid", readdatavalid, 1'b0);
    chk("rst_imm_rdata", readdata, 32'h0);
    @(posedge clock); #1;
    chk("rst_read_dropped", readdatavalid, 1'b0);
    read = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    cycle(1'b0, 1'b0, 4'd0, 32'h0, g);
    cycle(1'b1, 1'b0, 4'd8, 32'h0, g);  chk("rst_scr8", g, 32'h0);
    cycle(1'b1, 1'b0, 4'd9, 32'h0, g);  chk("rst_scr9", g, 32'h0);
    cycle(1'b1, 1'b0, 4'd5, 32'h0, g);  chk("rst_ctrl", g, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
